// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing generator.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;
    localparam int VGA640_HSYNC_POL = 0;
    localparam int VGA640_VSYNC_POL = 0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam int SVGA800_H_ACTIVE  = 800;
    localparam int SVGA800_H_FP      = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BP      = 88;
    localparam int SVGA800_V_ACTIVE  = 600;
    localparam int SVGA800_V_FP      = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BP      = 23;
    localparam int SVGA800_HSYNC_POL = 1;
    localparam int SVGA800_VSYNC_POL = 1;

    // Total length of one axis: visible + front porch + sync + back porch.
    function automatic int raster_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..total-1; never narrower than one bit.
    function automatic int raster_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-MAX counter with a combinational terminal-count strobe.
// wrap is high in the cycle where an enabled increment rolls count to 0.
module wrap_counter #(
    parameter int MAX = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = en && (count == LAST);

    // Count up on enable, rolling over to zero after the last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Walks the full raster on
// pix_en and produces registered sync/active decodes, strobes and a
// frame counter that all line up with the x/y they describe.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA640_H_ACTIVE,
    parameter int H_FP      = VGA640_H_FP,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BP      = VGA640_H_BP,
    parameter int V_ACTIVE  = VGA640_V_ACTIVE,
    parameter int V_FP      = VGA640_V_FP,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BP      = VGA640_V_BP,
    parameter int HSYNC_POL = VGA640_HSYNC_POL,
    parameter int VSYNC_POL = VGA640_VSYNC_POL,
    parameter int FRAME_W   = 8,
    localparam int H_TOTAL  = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL  = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW       = raster_width(H_TOTAL),
    localparam int YW       = raster_width(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        FRAME_W < 1) begin : g_bad_params
        $error("vga_timing_gen: every width parameter must be >= 1");
    end

    localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_FIRST  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON     = (HSYNC_POL != 0);
    localparam logic          VS_ON     = (VSYNC_POL != 0);

    logic          h_wrap;
    logic          v_wrap;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          act_next;
    logic          hs_next;
    logic          vs_next;

    wrap_counter #(.MAX(H_TOTAL), .W(XW)) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .count (x),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL), .W(YW)) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en & h_wrap),
        .count (y),
        .wrap  (v_wrap)
    );

    // Predict the position the counters will hold after this edge so the
    // registered decodes describe the same x/y they are presented with.
    always_comb begin
        x_next = x;
        y_next = y;
        if (reset) begin
            x_next = '0;
            y_next = '0;
        end else if (h_wrap) begin
            x_next = '0;
            y_next = v_wrap ? '0 : y + 1'b1;
        end else if (pix_en) begin
            x_next = x + 1'b1;
        end
        act_next = (x_next < H_ACT_END) && (y_next < V_ACT_END);
        hs_next  = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
        vs_next  = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
    end

    // Register decodes, wrap strobes and the completed-frame count.
    always_ff @(posedge clk) begin
        if (reset) begin
            active      <= 1'b1;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            active      <= act_next;
            hsync       <= hs_next ? HS_ON : ~HS_ON;
            vsync       <= vs_next ? VS_ON : ~VS_ON;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a small raster (8 x 6 pixels) so whole
// frames and frame-counter wraps fit in a short run.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
    localparam int V_ACTIVE = 3, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int HT = 8, VT = 6, FRAME = HT * VT;
    localparam int FRAME_W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         pix_en;
    logic [2:0]   x;
    logic [2:0]   y;
    logic         active, hsync, vsync, line_start, frame_start;
    logic [1:0]   frame_cnt;

    int total = 0;
    int bad   = 0;

    // model state: linear pixel index within frame and completed frames
    int m_pos    = 0;
    int m_frames = 0;
    bit m_line   = 0;
    bit m_frame  = 0;
    bit m_valid  = 0;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(1), .VSYNC_POL(0), .FRAME_W(FRAME_W)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model and per-cycle compare
    always @(posedge clk) begin
        int ex, ey;
        if (reset) begin
            m_pos = 0; m_frames = 0; m_line = 0; m_frame = 0; m_valid = 1;
        end else if (m_valid) begin
            if (pix_en) begin
                m_pos   = (m_pos + 1) % FRAME;
                m_line  = (m_pos % HT) == 0;
                m_frame = (m_pos == 0);
                if (m_pos == 0) m_frames++;
            end else begin
                m_line = 0; m_frame = 0;
            end
        end
        #1;
        if (m_valid) begin
            ex = m_pos % HT;
            ey = m_pos / HT;
            check("x", 32'(x), ex);
            check("y", 32'(y), ey);
            check("active", 32'(active), (ex < H_ACTIVE && ey < V_ACTIVE) ? 1 : 0);
            check("hsync", 32'(hsync),
                  (ex >= H_ACTIVE + H_FP && ex < H_ACTIVE + H_FP + H_SYNC) ? 1 : 0);
            check("vsync", 32'(vsync),
                  (ey >= V_ACTIVE + V_FP && ey < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1);
            check("line_start", 32'(line_start), m_line);
            check("frame_start", 32'(frame_start), m_frame);
            check("frame_cnt", 32'(frame_cnt), m_frames % (1 << FRAME_W));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_active"}, 32'(active), 1);
        check({tag, "_hsync"}, 32'(hsync), 0);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_line_start"}, 32'(line_start), 0);
        check({tag, "_frame_start"}, 32'(frame_start), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    // driver and hand-computed expectations
    initial begin
        int cycles, last_fs, last_ls, nfs, hs_cnt, vs_cnt, act_cnt;
        bit prev_ls, prev_fs, found;
        int fc_exp[4];
        fc_exp = '{2, 3, 0, 1};

        reset = 1'b1; pix_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // pix_en held high from release
        reset = 1'b0; pix_en = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_start && cycles < 4 * FRAME);
        check("first_frame_start_clk", cycles, FRAME);
        check("first_frame_cnt", 32'(frame_cnt), 1);

        last_fs = 0; last_ls = 0; nfs = 0;
        hs_cnt = 0; vs_cnt = 0; act_cnt = 0;
        for (int n = 1; n <= 4 * FRAME; n++) begin
            @(negedge clk);
            if (hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
            if (active) act_cnt++;
            if (x == 3'd5 || x == 3'd6) check("hsync_at_5_6", 32'(hsync), 1);
            if (x == 3'd4 || x == 3'd7) check("hsync_off_4_7", 32'(hsync), 0);
            if (line_start) begin
                check("line_period", n - last_ls, HT);
                last_ls = n;
            end
            if (frame_start) begin
                check("frame_period", n - last_fs, FRAME);
                check("frame_cnt_seq", 32'(frame_cnt), fc_exp[nfs]);
                last_fs = n;
                nfs++;
            end
        end
        check("frame_count_seen", nfs, 4);
        check("hsync_high_clks", hs_cnt, 4 * VT * H_SYNC);
        check("vsync_low_clks", vs_cnt, 4 * HT * V_SYNC);
        check("active_clks", act_cnt, 4 * H_ACTIVE * V_ACTIVE);

        // pix_en every second clk
        last_ls = -1; prev_ls = 0; prev_fs = 0;
        for (int n = 0; n < 10 * HT; n++) begin
            pix_en = (n % 2) == 0;
            @(negedge clk);
            check("ls_width", 32'(line_start & prev_ls), 0);
            check("fs_width", 32'(frame_start & prev_fs), 0);
            if (line_start) begin
                if (last_ls >= 0) check("half_rate_line_period", n - last_ls, 2 * HT);
                last_ls = n;
            end
            prev_ls = line_start;
            prev_fs = frame_start;
        end

        // reset mid-frame while pix_en is high
        pix_en = 1'b1;
        found = 0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            @(negedge clk);
            if (x == 3'd3 && y == 3'd2) found = 1;
        end
        check("reach_mid_frame", 32'(found), 1);
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_reset_values("midframe_reset");
        end
        reset = 1'b0;

        // randomized pix_en with occasional reset
        for (int n = 0; n < 3000; n++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0; pix_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 pixel counter. It walks the full raster including front porch, sync and back porch, and drives hsync, vsync, an active-video flag, line and frame strobes, and a frame counter. It advances only on a pixel-enable, so one system clock can serve any pixel rate. It feeds the sprite/tile renderers and the VGA output pins.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- FRAME_W, 8, frame counter width

Derived values:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
- XW = $clog2(H_TOTAL)
- YW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  advance raster by one pixel this cycle
- x  out  XW  current horizontal position, 0..H_TOTAL-1
- y  out  YW  current line, 0..V_TOTAL-1
- active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- hsync  out  1  horizontal sync at HSYNC_POL polarity
- vsync  out  1  vertical sync at VSYNC_POL polarity
- line_start  out  1  one-clk strobe after x wraps to 0
- frame_start  out  1  one-clk strobe after (x,y) wraps to (0,0)
- frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

## Operation

- Reset has priority over pix_en. All outputs take their reset values on the next clk edge.
- Reset values:
  - x = 0, y = 0, active = 1.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - line_start = 0, frame_start = 0, frame_cnt = 0.
- When pix_en = 0, x, y, active, hsync, vsync and frame_cnt hold their values. Both strobes are 0.
- When pix_en = 1:
  - If x < H_TOTAL-1, then x increments.
  - Otherwise x goes to 0, and y increments, or goes to 0 when y = V_TOTAL-1.
- hsync is asserted while H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1.
- vsync is asserted while V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1. vsync is line-based and independent of x.
- line_start is 1 for exactly one clk, in the cycle following a pix_en-qualified x wrap. It is not asserted on reset exit.
- frame_start is 1 for exactly one clk, in the cycle following a wrap of both x and y. line_start is also 1 in that cycle.
- frame_cnt increments on the same edge that sets frame_start.
- Back-to-back pix_en is legal. A wrap on consecutive pixels cannot occur unless H_TOTAL = 1, which is unsupported. Elaboration asserts every width parameter >= 1.

## Timing

- Every output is a flop.
- active, hsync and vsync are decoded from the next-state x/y. They therefore describe the x/y values presented in the same cycle, with zero relative latency.
- Latency from a pix_en edge to the updated x/y/decodes is 1 clk.
- Strobes coincide with the first cycle in which the new x/y values are visible.
- Period with pix_en held high:
  - line_start every H_TOTAL clks.
  - frame_start every H_TOTAL*V_TOTAL clks.
- With pix_en high 1 of every N cycles, each period scales by N.

## Structure

- Package vga_timing_pkg holds:
  - default 640x480@60 constants;
  - a second constant set for 800x600;
  - a localparam function that computes totals and widths.
- Sub-module wrap_counter:
  - parameters MAX and W;
  - inputs en and reset;
  - outputs count and wrap (combinational terminal-count-and-en).
- Two wrap_counter instances:
  - horizontal counter, en = pix_en;
  - vertical counter, en = pix_en & h.wrap.
- The top level adds the registered sync/active decode, the strobes and frame_cnt.

## Test plan

- Default parameters, pix_en held 1, reset released at t0:
  - first frame_start at clk 420000 after reset release;
  - frame_start recurs every 420000 clks;
  - line_start recurs every 800 clks;
  - frame_cnt reads 3 after 3 frames.
- Default parameters, pix_en = 1:
  - hsync = 0 exactly while x = 656..751, i.e. 96 clks per line;
  - vsync = 0 exactly while y = 490..491;
  - active = 1 only while x < 640 and y < 480.
- pix_en high every 2nd clk:
  - x advances once per 2 clks;
  - each strobe stays high for exactly 1 clk;
  - line period is 1600 clks;
  - all outputs hold during the idle cycles.
- Small config (H 4/1/2/1, V 3/1/1/1, HSYNC_POL = 1, FRAME_W = 2):
  - H_TOTAL = 8, V_TOTAL = 6;
  - hsync = 1 for x = 5..6;
  - frame_cnt sequence 0,1,2,3,0 at 48-clk spacing.
- Reset asserted mid-frame at x = 300, y = 200 while pix_en = 1:
  - next cycle: x = 0, y = 0, frame_cnt = 0, active = 1, syncs deasserted, no strobe.
- Reset and pix_en high together for 3 clks: outputs stay at reset values.
